// File: rtl/recon_pkg.sv
// rtl/recon_pkg.sv - shared constants, state type and helpers for the ICAP writer
package recon_pkg;

    localparam logic [31:0] ICAP_SYNC_WORD  = 32'hAA995566;
    localparam logic [31:0] ICAP_CMD_WR_HDR = 32'h30008001;
    localparam logic [31:0] ICAP_DESYNC_CMD = 32'h0000000D;

    // Widest tkeep the helper accepts; callers zero-extend narrower keeps.
    localparam int KEEP_MAX = 128;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } icap_state_t;

    typedef struct packed {
        logic       ok_shape;
        logic [7:0] bytes;
    } keep_info_t;

    // ICAP wants every byte presented MSB-first, byte positions unchanged.
    function automatic logic [31:0] byte_bitrev(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
        return r;
    endfunction

    // ok_shape: contiguous from bit 0 and a whole number of 32-bit words.
    function automatic keep_info_t keep_info(input logic [KEEP_MAX-1:0] keep);
        keep_info_t info;
        info.bytes = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            info.bytes = info.bytes + 8'(keep[i]);
        end
        info.ok_shape = ((keep & (keep + KEEP_MAX'(1))) == '0) && (info.bytes[1:0] == 2'b00);
        return info;
    endfunction

endpackage

// File: rtl/recon_icap_writer.sv
// rtl/recon_icap_writer.sv - serialises 512-bit stream beats into bit-swapped ICAPE3 writes
// Optional sync/desync word detection: RECON_ICAP_SYNC_DET_EN
module recon_icap_writer
    import recon_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ICAP_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    input  logic                  icap_avail,
    output logic                  icap_csib,
    output logic                  icap_rdwrb,
    output logic [ICAP_WIDTH-1:0] icap_i,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic                  frame_done,
    output logic                  err_keep,
    input  logic                  clear
`ifdef RECON_ICAP_SYNC_DET_EN
    ,
    output logic                  sync_seen,
    output logic                  desync_seen
`endif
);

    localparam int NW    = DATA_WIDTH / ICAP_WIDTH;
    localparam int IDX_W = $clog2(NW);
    localparam int NW_W  = IDX_W + 1;

    icap_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ICAP_WIDTH-1:0] words [NW];
    logic                  tlast_q;
    logic [NW_W-1:0]       nwords_q;
    logic [NW_W-1:0]       beat_nwords;
    logic [IDX_W-1:0]      idx_q;
    logic [ICAP_WIDTH-1:0] icap_q;
    logic [ICAP_WIDTH-1:0] cur_word;
    logic [ICAP_WIDTH-1:0] cur_swapped;
    keep_info_t            kinfo;
    logic                  keep_bad;
    logic                  accept;
    logic                  write;
    logic                  last_write;
    logic                  frame_done_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  count_q;

    for (genvar g = 0; g < NW; g++) begin : g_words
        assign words[g] = data_q[g*ICAP_WIDTH +: ICAP_WIDTH];
    end

    assign kinfo       = keep_info(KEEP_MAX'(s_axis_tkeep));
    assign beat_nwords = NW_W'(kinfo.bytes >> 2);
    assign keep_bad    = !kinfo.ok_shape || (!s_axis_tlast && !(&s_axis_tkeep));

    assign cur_word    = words[idx_q];
    assign cur_swapped = byte_bitrev(cur_word);

    // Gated by rst_n so the port goes quiet the moment reset is asserted, not one edge later.
    assign write      = rst_n && (state_q == ST_SHIFT) && icap_avail && ({1'b0, idx_q} < nwords_q);
    assign last_write = write && ({1'b0, idx_q} == nwords_q - NW_W'(1));

    assign s_axis_tready = rst_n && ((state_q == ST_IDLE) || last_write);
    assign accept        = s_axis_tready && s_axis_tvalid;

    assign icap_csib  = !write;
    assign icap_rdwrb = 1'b0;
    assign icap_i     = write ? cur_swapped : icap_q;
    assign word_count = count_q;
    assign frame_done = frame_done_q;
    assign err_keep   = err_q;

    // Zero-word beats never enter SHIFT; their frame_done is raised straight from accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (beat_nwords != '0)) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_write) state_d = (accept && (beat_nwords != '0)) ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) data_q <= s_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tlast_q      <= 1'b0;
            nwords_q     <= '0;
            idx_q        <= '0;
            icap_q       <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tlast_q  <= s_axis_tlast;
                nwords_q <= beat_nwords;
                idx_q    <= '0;
            end else if (write) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (write) icap_q <= cur_swapped;
            frame_done_q <= (last_write && tlast_q) ||
                            (accept && (beat_nwords == '0) && s_axis_tlast);
            if (clear)      count_q <= '0;
            else if (write) count_q <= count_q + CNT_WIDTH'(1);
            if (clear)                    err_q <= 1'b0;
            else if (accept && keep_bad)  err_q <= 1'b1;
        end
    end

`ifdef RECON_ICAP_SYNC_DET_EN
    logic sync_q, desync_q, cmd_prev_q;

    // Detection looks at the word as it sits in the stream, before the bit swap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= 1'b0;
            desync_q   <= 1'b0;
            cmd_prev_q <= 1'b0;
        end else begin
            if (write) cmd_prev_q <= (cur_word == ICAP_CMD_WR_HDR);
            if (clear || frame_done_q)                   sync_q <= 1'b0;
            else if (write && cur_word == ICAP_SYNC_WORD) sync_q <= 1'b1;
            if (clear || frame_done_q) desync_q <= 1'b0;
            else if (write && cmd_prev_q && cur_word == ICAP_DESYNC_CMD) desync_q <= 1'b1;
        end
    end

    assign sync_seen   = sync_q;
    assign desync_seen = desync_q;
`endif

endmodule

// File: tb/tb_recon_icap_writer.sv
// tb/tb_recon_icap_writer.sv - randomized self-checking bench for recon_icap_writer
// Sync/desync checks are built when RECON_ICAP_SYNC_DET_EN is defined
module tb_recon_icap_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] s_axis_tdata;
    logic [63:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic         icap_avail;
    logic         icap_csib;
    logic         icap_rdwrb;
    logic [31:0]  icap_i;
    logic [31:0]  word_count;
    logic         frame_done;
    logic         err_keep;
    logic         clear;
`ifdef RECON_ICAP_SYNC_DET_EN
    logic         sync_seen;
    logic         desync_seen;
`endif

    recon_icap_writer dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .icap_avail(icap_avail), .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb),
        .icap_i(icap_i), .word_count(word_count), .frame_done(frame_done),
        .err_keep(err_keep), .clear(clear)
`ifdef RECON_ICAP_SYNC_DET_EN
        , .sync_seen(sync_seen), .desync_seen(desync_seen)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          avail_mode = 0;
    int          writes_seen = 0;
    int          fd_seen = 0;
    int          exp_fd = 0;
    logic [31:0] exp_wc = '0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] swap_bits(input logic [31:0] w);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) begin
            logic [7:0] x;
            x = w[8*b +: 8];
            o[8*b +: 8] = {<<{x}};
        end
        return o;
    endfunction

    function automatic bit keep_ok(input logic [63:0] keep, input logic last);
        int n = $countones(keep);
        for (int i = 0; i < 64; i++) if (keep[i] != (i < n)) return 1'b0;
        if (n % 4 != 0) return 1'b0;
        if (!last && n != 64) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    always @(posedge clk) begin
        #2;
        case (avail_mode)
            0:       icap_avail = 1'b1;
            1:       icap_avail = !icap_avail;
            default: icap_avail = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (icap_csib !== 1'b1) begin
                writes_seen++;
                if (exp_q.size() == 0) chk("write_with_no_pending_word", 64'(exp_q.size() != 0), 64'd1);
                else                   chk("icap_i", icap_i, exp_q.pop_front());
            end
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    // Presents one beat, waits (bounded) for acceptance and loads the reference model.
    task automatic send(input logic [511:0] data, input logic [63:0] keep, input logic last);
        bit ok = 1'b0;
        s_axis_tdata  = data;
        s_axis_tkeep  = keep;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (s_axis_tready === 1'b1) begin
                ok = 1'b1;
                for (int w = 0; w < $countones(keep) / 4; w++) begin
                    exp_q.push_back(swap_bits(data[32*w +: 32]));
                    exp_wc++;
                end
                if (last) exp_fd++;
                if (!keep_ok(keep, last)) exp_err = 1'b1;
            end
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        if (!ok) chk("beat_accept_timeout", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("words_left_unwritten", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [511:0] d;
        logic [63:0]  k;
        logic [31:0]  w;
        rst_n = 1'b0; clear = 1'b0; icap_avail = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

        // reset state
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_csib", icap_csib, 1);
        chk("rst_rdwrb", icap_rdwrb, 0);
        chk("rst_icap_i", icap_i, 0);
        chk("rst_word_count", word_count, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_keep", err_keep, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;

        // one full tlast beat; stream words 1..16 laid out byte-serially across the lanes
        for (int i = 0; i < 16; i++) begin
            w = 32'(i + 1);
            d[32*i +: 32] = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end
        send(d, '1, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            chk("full_csib", icap_csib, 0);
            if (c == 1) chk("full_first_icap_i", icap_i, 32'h8000_0000);
            chk("full_tready", s_axis_tready, 64'(c == 16));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_frame_done", frame_done, 1);
        chk("full_word_count", word_count, 16);
        drain();

        // back-to-back beats under alternating AVAIL
        avail_mode = 1;
        send(rand_beat(), '1, 1'b0);
        send(rand_beat(), '1, 1'b1);
        drain();
        chk("b2b_word_count", word_count, exp_wc);
        chk("b2b_frames", fd_seen, exp_fd);

        // legal partial last beat
        avail_mode = 0;
        send(rand_beat(), 64'h0000_FFFF, 1'b1);
        drain();
        chk("partial_word_count", word_count, exp_wc);
        chk("partial_err_keep", err_keep, 0);

        // partial beat without tlast is a keep error but still written
        send(rand_beat(), 64'h0000_0FFF, 1'b0);
        drain();
        chk("nolast_err_keep", err_keep, 1);
        chk("nolast_word_count", word_count, exp_wc);

        // clear coincides with the first write of a beat
        send(rand_beat(), '1, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_word_count", word_count, 0);
        chk("clear_err_keep", err_keep, 0);
        exp_wc = 32'd15;
        exp_err = 1'b0;
        drain();
        chk("post_clear_word_count", word_count, exp_wc);

        // empty tlast beat: no write, frame_done right after accept
        send(rand_beat(), '0, 1'b1);
        @(negedge clk);
        chk("empty_frame_done", frame_done, 1);
        chk("empty_csib", icap_csib, 1);
        @(posedge clk); #1;
        drain();

        // randomized beats, keeps and AVAIL
        avail_mode = 2;
        for (int b = 0; b < 24; b++) begin
            case ($urandom_range(0, 3))
                0:       k = '1;
                1:       k = (64'd1 << (4 * $urandom_range(0, 15))) - 64'd1;
                2:       k = {$urandom, $urandom};
                default: k = (64'd1 << $urandom_range(1, 63)) - 64'd1;
            endcase
            send(rand_beat(), k, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();
        chk("rand_word_count", word_count, exp_wc);
        chk("rand_frames", fd_seen, exp_fd);
        chk("rand_err_keep", err_keep, exp_err);

        // reset in the middle of a beat drops the rest of it
        avail_mode = 0;
        send(rand_beat(), '1, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_csib", icap_csib, 1);
        chk("midrst_tready", s_axis_tready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_tready_held", s_axis_tready, 0);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        writes_seen = 0; fd_seen = 0; exp_fd = 0; exp_wc = '0; exp_err = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_writes", writes_seen, 0);
        chk("midrst_word_count", word_count, 0);
        chk("midrst_no_frame_done", fd_seen, 0);
        @(posedge clk); #1;

`ifdef RECON_ICAP_SYNC_DET_EN
        d = rand_beat();
        d[31:0] = 32'hFFFF_FFFF; d[63:32] = 32'hAA99_5566;
        d[95:64] = 32'h3000_8001; d[127:96] = 32'h0000_000D;
        send(d, 64'h0000_FFFF, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("sync_after_2nd", sync_seen, 1);
        chk("desync_before_4th", desync_seen, 0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("desync_after_4th", desync_seen, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("sync_cleared", sync_seen, 0);
        chk("desync_cleared", desync_seen, 0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
